alu_cmp_serial: RTL and testbench
=================================

ALU_CMP_SERIAL -- requirements
Module: alu_cmp_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands and mode present.
REQ-006 SHALL have port in_ready  output  1  block accepts a new compare.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port u_s  input  1  1 = unsigned compare, 0 = signed compare.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port less  output  1  a < b under captured mode.
REQ-013 SHALL have port equal  output  1  a == b.
REQ-014 SHALL have port o_Result  output  WIDTH  set-less-than value, zero-extended less.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE: on in_valid & in_ready, SHALL capture a, b, u_s, load chunk index N-1, go to BUSY.
REQ-018 Signed mode SHALL be realised by inverting bit WIDTH-1 of both captured operands, then comparing unsigned.
REQ-019 BUSY: each cycle SHALL compare one CHUNK-bit slice, MSB slice first, index decrementing.
REQ-020 BUSY: first differing slice SHALL set less = (slice_a < slice_b), equal = 0, go to DONE (early termination).
REQ-021 BUSY: slice index 0 equal SHALL set less = 0, equal = 1, go to DONE.
REQ-022 Latency from accept edge to out_valid SHALL be k+1 cycles, k = number of slices examined (min 2, max N+1).
REQ-023 DONE: less, equal, o_Result SHALL hold stable while out_ready = 0.
REQ-024 DONE: out_valid & out_ready SHALL return to IDLE next cycle; no acceptance in the same cycle.
REQ-025 Inputs a, b, u_s SHALL be ignored outside the accept cycle.
REQ-026 o_Result SHALL equal {WIDTH-1 zeros, less}.

Reset
REQ-027 rst = 1 SHALL immediately force IDLE, in_ready = 1, out_valid = 0, less = 0, equal = 0, o_Result = 0, operand registers and index = 0.
REQ-028 Reset during BUSY or DONE SHALL discard the in-flight compare; no out_valid follows.

Structure
REQ-029 Package alu_pkg SHALL hold the FSM state enum and the default WIDTH/CHUNK constants.
REQ-030 One combinational sub-module chunk_cmp (CHUNK-bit slice -> lt, gt) SHALL be instantiated once.

Verification (WIDTH=32, CHUNK=8)
REQ-031 a=0xFFFFFFFF, b=0x00000001, u_s=0 -> less=1, equal=0, o_Result=1, out_valid 2 cycles after accept.
REQ-032 same operands, u_s=1 -> less=0, equal=0, o_Result=0, latency 2.
REQ-033 a=b=0x12345678, u_s=0 -> equal=1, less=0, latency 5.
REQ-034 a=0x00000010, b=0x00000011, u_s=1 -> less=1, latency 5; in_ready=0 throughout BUSY/DONE.
REQ-035 out_ready held 0 for 3 cycles in DONE -> outputs unchanged, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-036 rst asserted during second BUSY cycle -> out_valid=0, in_ready=1 without waiting for clk; next compare correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_t   : controller states (IDLE accepts, BUSY scans slices, DONE holds result)
//   DEF_WIDTH : default operand width in bits
//   DEF_CHUNK : default number of bits compared per BUSY cycle
package alu_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index register width; kept at least one bit so a single-slice build still elaborates.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned comparison of one CHUNK-bit slice.
//   slice_a, slice_b : slice operands
//   lt               : slice_a <  slice_b
//   gt               : slice_a >  slice_b
// Both low means the slices are equal.
module chunk_cmp #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] slice_a,
  input  logic [CHUNK-1:0] slice_b,
  output logic             lt,
  output logic             gt
);

  always_comb begin
    lt = (slice_a < slice_b);
    gt = (slice_a > slice_b);
  end

endmodule

// File: rtl/alu_cmp_serial.sv
// Serial signed/unsigned magnitude comparator producing a set-less-than result.
// One CHUNK-bit slice is compared per BUSY cycle, most significant slice first,
// stopping at the first slice that differs.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake carrying a, b and u_s
//   a, b                : operands (sampled only on the accept edge)
//   u_s                 : 1 = unsigned compare, 0 = signed compare
//   out_valid/out_ready : result handshake
//   less, equal         : comparison result
//   o_Result            : zero-extended less
module alu_cmp_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             u_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             less,
  output logic             equal,
  output logic [WIDTH-1:0] o_Result
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = idx_width(N);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx_q;
  logic             hit_q;
  logic             less_q, equal_q;

  logic [CHUNK-1:0] slice_a, slice_b;
  logic             slice_lt, slice_gt;
  logic             accept;
  logic             last_slice;

  // Slice select from the captured operands.
  always_comb begin
    slice_a    = a_q[idx_q*CHUNK +: CHUNK];
    slice_b    = b_q[idx_q*CHUNK +: CHUNK];
    accept     = (state_q == IDLE) && in_valid;
    last_slice = (idx_q == '0);
  end

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .slice_a (slice_a),
    .slice_b (slice_b),
    .lt      (slice_lt),
    .gt      (slice_gt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The decision from the scanned slice is registered in
  // hit_q, so DONE is entered one cycle after the deciding slice.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (hit_q)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, slice scan and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      less_q  <= 1'b0;
      equal_q <= 1'b0;
    end else if (accept) begin
      // Flipping the sign bits maps two's-complement order onto unsigned order.
      a_q     <= {a[WIDTH-1] ^ ~u_s, a[WIDTH-2:0]};
      b_q     <= {b[WIDTH-1] ^ ~u_s, b[WIDTH-2:0]};
      idx_q   <= IDX_W'(N - 1);
      hit_q   <= 1'b0;
      less_q  <= 1'b0;
      equal_q <= 1'b0;
    end else if (state_q == BUSY && !hit_q) begin
      if (slice_lt || slice_gt) begin
        hit_q   <= 1'b1;
        less_q  <= slice_lt;
        equal_q <= 1'b0;
      end else if (last_slice) begin
        hit_q   <= 1'b1;
        less_q  <= 1'b0;
        equal_q <= 1'b1;
      end else begin
        idx_q   <= idx_q - 1'b1;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    less      = less_q;
    equal     = equal_q;
    o_Result  = {{(WIDTH-1){1'b0}}, less_q};
  end

endmodule

// File: tb/tb_alu_cmp_serial.sv
// Directed-vector bench for alu_cmp_serial (WIDTH=32, CHUNK=8).
module tb_alu_cmp_serial;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        u_s;
  logic        out_valid;
  logic        out_ready;
  logic        less;
  logic        equal;
  logic [31:0] o_Result;

  int unsigned n_vec;
  int unsigned n_err;

  alu_cmp_serial #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .u_s       (u_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .less      (less),
    .equal     (equal),
    .o_Result  (o_Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Issue one compare, measure latency, check the result, hold it for
  // hold_cycles with out_ready low, then release it.
  task automatic run_cmp(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vus, input logic exp_less, input logic exp_eq,
                         input int unsigned exp_lat, input int unsigned hold_cycles);
    int unsigned lat;
    @(negedge clk);
    a = va; b = vb; u_s = vus; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~va; b = va ^ 32'h5A5A_A5A5; u_s = ~vus;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (in_ready !== 1'b0) chk({tag, "_rdy_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_less"}, 32'(less), 32'(exp_less));
    chk({tag, "_equal"}, 32'(equal), 32'(exp_eq));
    chk({tag, "_res"}, o_Result, {31'd0, exp_less});
    chk({tag, "_rdy_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < int'(hold_cycles); i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_res"}, {less, equal, o_Result[29:0]}, {exp_less, exp_eq, 29'd0, exp_less});
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    // Offer a new request during the release cycle; it must not be taken.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_rel_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; u_s = 1'b0;
    #12;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_out", {30'd0, less, equal}, 32'd0);
    chk("rst_res", o_Result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_cmp("neg1_vs_1_s",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 2, 0);
    run_cmp("neg1_vs_1_u",   32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 2, 0);
    run_cmp("eq_s_hold",     32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 5, 3);
    run_cmp("lsb_u",         32'h0000_0010, 32'h0000_0011, 1'b1, 1'b1, 1'b0, 5, 0);
    run_cmp("min_vs_max_s",  32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 2, 0);
    run_cmp("min_vs_max_u",  32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 2, 0);
    run_cmp("slice1_u",      32'h1234_5600, 32'h1234_5700, 1'b1, 1'b1, 1'b0, 4, 0);
    run_cmp("slice2_s",      32'h00FF_0000, 32'h00FE_0000, 1'b0, 1'b0, 1'b0, 3, 1);

    // Reset in the second BUSY cycle of a full-length compare.
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1234_5678; u_s = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_rdy", 32'(in_ready), 32'd1);
    chk("arst_out", {30'd0, less, equal}, 32'd0);
    chk("arst_res", o_Result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        chk("arst_discard", {30'd0, out_valid, in_ready}, 32'd1);
    end
    n_vec++;
    run_cmp("post_rst",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
